// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
// The optional per-requester beat counters use STAT_W (see FIFO_WR_ARB_STATS_EN).
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned STAT_W        = 16;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning last+1, last+2, ...
// wrapping modulo NUM_REQ, so the previous winner has the lowest priority.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one fifo write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add the saturating per-requester beat_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      fifo_full
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] beat_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   last, last_n;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               beat;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            gnt       <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            burst_cnt <= burst_cnt_n;
            gnt       <= gnt_n;
        end
    end

    // gnt is one-hot on the owner while BUSY, so gnt & req isolates req[owner].
    always_comb begin
        ack = '0;
        if (state == BUSY && !fifo_full) begin
            ack = gnt & req;
        end
        beat          = |ack;
        fifo_write_en = beat;
        fifo_data_in  = '0;
        if (state == BUSY) begin
            fifo_data_in = req_data[owner*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        burst_cnt_n = burst_cnt;
        gnt_n       = gnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n     = BUSY;
                    owner_n     = pick_idx;
                    last_n      = pick_idx;
                    burst_cnt_n = '0;
                    gnt_n       = NUM_REQ'(1) << pick_idx;
                end
            end
            BUSY: begin
                if (beat) begin
                    burst_cnt_n = burst_cnt + 1'b1;
                end
                if (!req[owner] || (beat && burst_cnt == CNT_LAST)) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                stat_q[i] <= '0;
            end else if (ack[i] && stat_q[i] != '1) begin
                stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        beat_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            beat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`endif

endmodule
